nbit_parity_stream: RTL and testbench

Streaming, frame-based parity generator built from the team's XOR2 cell. Accepts N-bit words over a valid/ready handshake, accumulates parity across a multi-word frame terminated by `in_last`, and emits one parity result per frame in even or odd mode, with a word count and overflow flag. Sits between a word source and a link framer that appends the parity bit. Generalises the combinational N-bit XOR to a clocked multi-word, multi-mode block with backpressure.

---
 rtl/nbit_parity_stream.sv | 150 +++++++++++++++
 tb/tb_nbit_parity_stream.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/nbit_parity_stream.sv
// nbit_parity_stream: frame-based streaming parity generator.
// Words arrive over valid/ready. Parity is accumulated across a frame that ends with in_last.
// One registered result is produced per frame: the parity bit, a saturating word count and
// an overflow flag. While a result is pending, only a frame's last word is held off, so
// mid-frame words keep flowing into the accumulator.
module nbit_parity_stream #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_last,
    input  logic          odd_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_parity,
    output logic [CW-1:0] out_count,
    output logic          out_ovf
);

    localparam int Depth = $clog2(N);
    localparam logic [CW-1:0] CntMax = '1;
    localparam logic [CW-1:0] CntOne = CW'(1);

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    // Number of nodes on tree level k: ceil(N / 2^k).
    function automatic int lvl_width(input int k);
        return (int'(N) + (1 << k) - 1) >> k;
    endfunction

    // Balanced XOR2 tree. Each level pairs neighbours, and an odd leftover passes straight
    // through. That gives exactly N-1 gates and ceil(log2 N) levels for any N.
    for (genvar k = 0; k <= Depth; k++) begin : g_lvl
        localparam int W = lvl_width(k);
        logic [W-1:0] v;
        if (k == 0) begin : g_leaf
            assign v = in_data;
        end else begin : g_node
            localparam int Wp = lvl_width(k - 1);
            for (genvar j = 0; j < W; j++) begin : g_bit
                if (2 * j + 1 < Wp) begin : g_xor
                    xor u_xor2 (v[j], g_lvl[k-1].v[2*j], g_lvl[k-1].v[2*j+1]);
                end else begin : g_pass
                    assign v[j] = g_lvl[k-1].v[2*j];
                end
            end
        end
    end

    logic wpar;
    assign wpar = g_lvl[Depth].v[0];

    state_e        state_q, state_d;
    logic          par_acc_q, par_acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mode_q, mode_d;
    logic          out_valid_q, out_valid_d;
    logic          out_parity_q, out_parity_d;
    logic [CW-1:0] out_count_q, out_count_d;
    logic          out_ovf_q, out_ovf_d;

    logic          acc;
    logic          first;
    logic          par_base;
    logic [CW-1:0] cnt_base;
    logic [CW-1:0] cnt_inc;
    logic          mode_cur;

    // A pending result blocks only the word that would overwrite it: a last word.
    assign in_ready = !reset && (!out_valid_q || out_ready || !in_last);
    assign acc      = in_valid && in_ready;

    // In IDLE the incoming word opens a frame, so the accumulator and count start from zero.
    // The mode is also taken live from odd_mode for that first word.
    always_comb begin
        first    = (state_q == StIdle);
        par_base = first ? 1'b0 : par_acc_q;
        cnt_base = first ? '0 : cnt_q;
        mode_cur = first ? odd_mode : mode_q;
        cnt_inc  = (cnt_base == CntMax) ? CntMax : cnt_base + CntOne;
    end

    // Next-state and result logic; everything holds unless a word is accepted or drained.
    always_comb begin
        state_d      = state_q;
        par_acc_d    = par_acc_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        out_valid_d  = out_valid_q;
        out_parity_d = out_parity_q;
        out_count_d  = out_count_q;
        out_ovf_d    = out_ovf_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (acc) begin
            if (first) begin
                mode_d = odd_mode;
            end
            if (in_last) begin
                out_valid_d  = 1'b1;
                out_parity_d = par_base ^ wpar ^ mode_cur;
                out_count_d  = cnt_inc;
                out_ovf_d    = (cnt_base == CntMax);
                par_acc_d    = 1'b0;
                cnt_d        = '0;
                state_d      = StIdle;
            end else begin
                par_acc_d = par_base ^ wpar;
                cnt_d     = cnt_inc;
                state_d   = StAccum;
            end
        end
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            par_acc_q    <= 1'b0;
            cnt_q        <= '0;
            mode_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_parity_q <= 1'b0;
            out_count_q  <= '0;
            out_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            par_acc_q    <= par_acc_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            out_valid_q  <= out_valid_d;
            out_parity_q <= out_parity_d;
            out_count_q  <= out_count_d;
            out_ovf_q    <= out_ovf_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_parity = out_parity_q;
    assign out_count  = out_count_q;
    assign out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_nbit_parity_stream.sv
// Directed bench for nbit_parity_stream.
// Instance a: N=8, CW=8.
// Instance b: N=8, CW=2, used for saturation.
// Instance c: N=5, CW=8, an uneven XOR tree fed from in_data[4:0].
// All instances share the same inputs. Inputs are driven on the falling edge, and outputs
// are read on the falling edge.
module tb_nbit_parity_stream;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       odd_mode;
    logic       out_ready;

    logic       a_in_ready, a_out_valid, a_out_parity, a_out_ovf;
    logic [7:0] a_out_count;
    logic       b_in_ready, b_out_valid, b_out_parity, b_out_ovf;
    logic [1:0] b_out_count;
    logic       c_in_ready, c_out_valid, c_out_parity, c_out_ovf;
    logic [7:0] c_out_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nbit_parity_stream #(.N(8), .CW(8)) u_dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last), .odd_mode(odd_mode),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_parity(a_out_parity),
        .out_count(a_out_count), .out_ovf(a_out_ovf)
    );

    nbit_parity_stream #(.N(8), .CW(2)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last), .odd_mode(odd_mode),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_parity(b_out_parity),
        .out_count(b_out_count), .out_ovf(b_out_ovf)
    );

    nbit_parity_stream #(.N(5), .CW(8)) u_dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data[4:0]), .in_last(in_last), .odd_mode(odd_mode),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_parity(c_out_parity),
        .out_count(c_out_count), .out_ovf(c_out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one word. Return on the falling edge after it is accepted, with in_valid dropped.
    task automatic put(input logic [7:0] d, input logic l, input logic m);
        int k = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        odd_mode = m;
        #1;
        while (!a_in_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!a_in_ready) begin
            check("accept_timeout", 32'(a_in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        odd_mode  = 1'b0;
        out_ready = 1'b1;

        // Power-on reset.
        @(negedge clk);
        #1 check("rst_in_ready", 32'(a_in_ready), 0);
        @(negedge clk);
        check("rst_valid", 32'(a_out_valid), 0);
        check("rst_parity", 32'(a_out_parity), 0);
        check("rst_count", 32'(a_out_count), 0);
        check("rst_ovf", 32'(a_out_ovf), 0);
        reset = 1'b0;
        #1 check("rst_release_ready", 32'(a_in_ready), 1);
        @(negedge clk);

        // Multi-word even frame: 0x03 ^ 0x01 ^ 0xFF -> 1 (N=8). Low 5 bits give 0 (N=5).
        put(8'h03, 1'b0, 1'b0);
        put(8'h01, 1'b0, 1'b0);
        check("mw_valid_early", 32'(a_out_valid), 0);
        put(8'hFF, 1'b1, 1'b0);
        check("mw_valid", 32'(a_out_valid), 1);
        check("mw_parity", 32'(a_out_parity), 1);
        check("mw_count", 32'(a_out_count), 3);
        check("mw_ovf", 32'(a_out_ovf), 0);
        check("mw_n5_parity", 32'(c_out_parity), 0);
        @(negedge clk);
        check("mw_valid_clear", 32'(a_out_valid), 0);

        // Odd mode is latched on the first word; the toggle on the last word is ignored.
        put(8'h00, 1'b0, 1'b1);
        put(8'h00, 1'b1, 1'b0);
        check("odd_parity", 32'(a_out_parity), 1);
        check("odd_count", 32'(a_out_count), 2);
        @(negedge clk);

        // Backpressure. The first result is 0x0F even -> 0, and it stays pending.
        out_ready = 1'b0;
        put(8'h0F, 1'b1, 1'b0);
        check("bp_a_parity", 32'(a_out_parity), 0);
        check("bp_a_count", 32'(a_out_count), 1);
        // Mid-frame words still go in. The odd frame gives 0x07^0x01^0x10 = 1, then ^1 -> 0.
        put(8'h07, 1'b0, 1'b1);
        put(8'h01, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h10;
        in_last  = 1'b1;
        odd_mode = 1'b0;
        #1 check("bp_last_blocked", 32'(a_in_ready), 0);
        @(negedge clk);
        #1 check("bp_last_blocked2", 32'(a_in_ready), 0);
        check("bp_hold_valid", 32'(a_out_valid), 1);
        check("bp_hold_parity", 32'(a_out_parity), 0);
        check("bp_hold_count", 32'(a_out_count), 1);
        out_ready = 1'b1;
        #1 check("bp_last_ready", 32'(a_in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_b_valid", 32'(a_out_valid), 1);
        check("bp_b_parity", 32'(a_out_parity), 0);
        check("bp_b_count", 32'(a_out_count), 3);
        @(negedge clk);
        check("bp_drained", 32'(a_out_valid), 0);

        // Saturation on CW=2. Five words of 0x80 give parity 1.
        for (int i = 0; i < 5; i++) put(8'h80, (i == 4), 1'b0);
        check("sat_count", 32'(b_out_count), 3);
        check("sat_ovf", 32'(b_out_ovf), 1);
        check("sat_parity", 32'(b_out_parity), 1);
        check("sat_wide_count", 32'(a_out_count), 5);
        check("sat_wide_ovf", 32'(a_out_ovf), 0);
        // Three words fit exactly in CW=2, so there is no overflow.
        for (int i = 0; i < 3; i++) put(8'h80, (i == 2), 1'b0);
        check("sat3_count", 32'(b_out_count), 3);
        check("sat3_ovf", 32'(b_out_ovf), 0);
        // Four words is the first overflow.
        for (int i = 0; i < 4; i++) put(8'h80, (i == 3), 1'b0);
        check("sat4_ovf", 32'(b_out_ovf), 1);
        check("sat4_parity", 32'(b_out_parity), 0);
        @(negedge clk);

        // Reset with a result pending and a frame open discards both.
        out_ready = 1'b0;
        put(8'h01, 1'b1, 1'b0);
        put(8'h03, 1'b0, 1'b0);
        reset = 1'b1;
        #1 check("mrst_in_ready", 32'(a_in_ready), 0);
        @(negedge clk);
        @(negedge clk);
        check("mrst_valid", 32'(a_out_valid), 0);
        check("mrst_parity", 32'(a_out_parity), 0);
        check("mrst_count", 32'(a_out_count), 0);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1 check("mrst_ready_after", 32'(a_in_ready), 1);
        put(8'h01, 1'b1, 1'b0);
        check("mrst_parity_after", 32'(a_out_parity), 1);
        check("mrst_count_after", 32'(a_out_count), 1);

        // A single-word odd frame takes its mode live from odd_mode.
        put(8'h00, 1'b1, 1'b1);
        check("single_odd_parity", 32'(a_out_parity), 1);

        // The uneven tree sees only the low 5 bits: 0xF1 gives 1 for N=8 and 0 for N=5.
        put(8'hF1, 1'b1, 1'b0);
        check("n8_f1_parity", 32'(a_out_parity), 1);
        check("n5_f1_parity", 32'(c_out_parity), 0);
        @(negedge clk);

        // Back-to-back single-word frames. Results arrive one per cycle, and in_ready stays 1.
        put(8'h01, 1'b1, 1'b0);
        t0 = cyc;
        check("b2b_p0", 32'(a_out_parity), 1);
        check("b2b_ready0", 32'(a_in_ready), 1);
        put(8'h03, 1'b1, 1'b0);
        check("b2b_cycle1", 32'(cyc - t0), 1);
        check("b2b_v1", 32'(a_out_valid), 1);
        check("b2b_p1", 32'(a_out_parity), 0);
        check("b2b_ready1", 32'(a_in_ready), 1);
        put(8'h07, 1'b1, 1'b0);
        check("b2b_cycle2", 32'(cyc - t0), 2);
        check("b2b_p2", 32'(a_out_parity), 1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
